// File: rtl/display_source_mux.sv
// Selects one of SOURCES captured digit sets for display. Manual advance comes from a debounced button and auto-advance from a dwell timer.
// Latency: 2 cycles from src_valid or an advance event to out_dig/out_src. No backpressure; hold freezes the outputs only.
module display_source_mux #(
  parameter  int DIG_W    = 4,
  parameter  int CHANNELS = 4,
  parameter  int SOURCES  = 2,
  parameter  int DWELL    = 50_000_000,
  parameter  int DEB      = 16,
  localparam int SW       = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [SOURCES*CHANNELS*DIG_W-1:0]   src_data,
  input  logic [SOURCES-1:0]                  src_valid,
  input  logic                                sel_btn,
  input  logic                                auto_en,
  input  logic                                hold,
  output logic [CHANNELS*DIG_W-1:0]           out_dig,
  output logic [SW-1:0]                       out_src,
  output logic                                out_upd
);
  localparam int SLICE = CHANNELS * DIG_W;
  localparam int DW_W  = $clog2(DWELL);
  localparam int DB_W  = $clog2(DEB);

  logic [SLICE-1:0] r_snap [SOURCES];
  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb_lvl;
  logic [DB_W-1:0]  r_deb_cnt;
  logic [DW_W-1:0]  r_dwell;
  logic [SW-1:0]    r_idx;
  logic [SLICE-1:0] r_out_dig;
  logic [SW-1:0]    r_out_src;
  logic             r_out_upd;

  logic             w_deb_flip;
  logic             w_man_adv;
  logic             w_auto_adv;
  logic             w_adv;
  logic [SLICE-1:0] w_cur;

  // The level flips on the DEB-th consecutive cycle that disagrees with it.
  assign w_deb_flip = (r_sync2 != r_deb_lvl) && (r_deb_cnt == DB_W'(DEB - 1));
  assign w_man_adv  = w_deb_flip && !r_deb_lvl;
  assign w_auto_adv = auto_en && (r_dwell == DW_W'(DWELL - 1));
  assign w_adv      = w_man_adv || w_auto_adv;
  assign w_cur      = r_snap[r_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SOURCES; s++) r_snap[s] <= '0;
    end else begin
      for (int s = 0; s < SOURCES; s++) begin
        if (src_valid[s]) r_snap[s] <= src_data[s*SLICE +: SLICE];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb_lvl <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= sel_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb_lvl) begin
        r_deb_cnt <= '0;
      end else if (w_deb_flip) begin
        r_deb_lvl <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DB_W'(1);
      end
    end
  end

  // A manual advance restarts the dwell so a press always buys a full interval.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dwell <= '0;
      r_idx   <= '0;
    end else begin
      if (!auto_en || w_adv) r_dwell <= '0;
      else                   r_dwell <= r_dwell + DW_W'(1);
      if (w_adv) r_idx <= (r_idx == SW'(SOURCES - 1)) ? '0 : r_idx + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_dig <= '0;
      r_out_src <= '0;
      r_out_upd <= 1'b0;
    end else if (!hold) begin
      r_out_dig <= w_cur;
      r_out_src <= r_idx;
      r_out_upd <= (w_cur != r_out_dig) || (r_idx != r_out_src);
    end else begin
      r_out_upd <= 1'b0;
    end
  end

  assign out_dig = r_out_dig;
  assign out_src = r_out_src;
  assign out_upd = r_out_upd;

endmodule

// File: tb/tb_display_source_mux.sv
// Drives a 2-source and a 3-source instance from shared stimulus and compares
// every cycle against a behavioural model, plus directed scenario checks.
module tb_display_source_mux;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [47:0] src_data = '0;
  logic [2:0]  src_valid = '0;
  logic        sel_btn = 1'b0;
  logic        auto_en = 1'b0;
  logic        hold = 1'b0;

  logic [15:0] out_dig2, out_dig3;
  logic        out_src2;
  logic [1:0]  out_src3;
  logic        out_upd2, out_upd3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  display_source_mux #(.DIG_W(4), .CHANNELS(4), .SOURCES(2), .DWELL(50), .DEB(DEB)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .src_data(src_data[31:0]), .src_valid(src_valid[1:0]),
    .sel_btn(sel_btn), .auto_en(auto_en), .hold(hold),
    .out_dig(out_dig2), .out_src(out_src2), .out_upd(out_upd2));

  display_source_mux #(.DIG_W(4), .CHANNELS(4), .SOURCES(3), .DWELL(10), .DEB(DEB)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .src_data(src_data), .src_valid(src_valid),
    .sel_btn(sel_btn), .auto_en(auto_en), .hold(hold),
    .out_dig(out_dig3), .out_src(out_src3), .out_upd(out_upd3));

  // Reference model: index 0 is the 2-source unit, index 1 the 3-source unit.
  int          nsrc [2] = '{2, 3};
  int          ndw  [2] = '{50, 10};
  logic [15:0] m_snap [2][3];
  int          m_idx [2];
  int          m_dw  [2];
  int          m_run [2];
  logic        m_s1  [2];
  logic        m_s2  [2];
  logic        m_lvl [2];
  logic [15:0] m_dig [2];
  int          m_src [2];
  logic        m_upd [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) m_snap[k][s] = '0;
      m_idx[k] = 0; m_dw[k] = 0; m_run[k] = 0;
      m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0;
      m_dig[k] = '0; m_src[k] = 0; m_upd[k] = 0;
    end
  endtask

  task automatic model_step();
    bit man, aut;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      man = 0;
      if (m_s2[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_lvl[k] = m_s2[k];
          m_run[k] = 0;
          man = m_lvl[k];
        end
      end else begin
        m_run[k] = 0;
      end
      aut = auto_en && (m_dw[k] == ndw[k] - 1);
      if (!auto_en || man || aut) m_dw[k] = 0;
      else                        m_dw[k]++;
      if (!hold) begin
        m_upd[k] = (m_snap[k][m_idx[k]] != m_dig[k]) || (m_idx[k] != m_src[k]);
        m_dig[k] = m_snap[k][m_idx[k]];
        m_src[k] = m_idx[k];
      end else begin
        m_upd[k] = 0;
      end
      if (man || aut) m_idx[k] = (m_idx[k] + 1) % nsrc[k];
      for (int s = 0; s < nsrc[k]; s++)
        if (src_valid[s]) m_snap[k][s] = src_data[s*16 +: 16];
      m_s2[k] = m_s1[k];
      m_s1[k] = sel_btn;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("dig2", 64'(out_dig2), 64'(m_dig[0]));
    chk("src2", 64'(out_src2), 64'(m_src[0]));
    chk("upd2", 64'(out_upd2), 64'(m_upd[0]));
    chk("dig3", 64'(out_dig3), 64'(m_dig[1]));
    chk("src3", 64'(out_src3), 64'(m_src[1]));
    chk("upd3", 64'(out_upd3), 64'(m_upd[1]));
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    chk("arst_dig2", 64'(out_dig2), 64'd0);
    chk("arst_src2", 64'(out_src2), 64'd0);
    chk("arst_dig3", 64'(out_dig3), 64'd0);
    chk("arst_src3", 64'(out_src3), 64'd0);
    chk("arst_upd3", 64'(out_upd3), 64'd0);
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    int q_cyc[$];
    int q_val[$];
    int prev, nchg, sv, n;
    logic [15:0] sd;

    // Reset state
    #3 reset_n = 1'b0;
    model_reset();
    cyc(); cyc();
    chk("rst_dig2", 64'(out_dig2), 64'd0);
    chk("rst_upd2", 64'(out_upd2), 64'd0);
    reset_n = 1'b1;

    // Capture
    src_data = {16'h0000, 16'hABCD, 16'h1234};
    src_valid = 3'b011;
    cyc();
    src_valid = 3'b000;
    cyc();
    chk("cap_dig", 64'(out_dig2), 64'h1234);
    chk("cap_src", 64'(out_src2), 64'd0);
    chk("cap_upd", 64'(out_upd2), 64'd1);
    cyc();
    chk("cap_upd_once", 64'(out_upd2), 64'd0);

    // Manual advance and wrap
    for (int p = 0; p < 2; p++) begin
      sel_btn = 1'b1;
      for (int i = 0; i < DEB + 2; i++) cyc();
      sel_btn = 1'b0;
      for (int i = 0; i < 12; i++) cyc();
      chk("man_src", 64'(out_src2), (p == 0) ? 64'd1 : 64'd0);
      chk("man_dig", 64'(out_dig2), (p == 0) ? 64'hABCD : 64'h1234);
    end

    // Bounce
    for (int i = 0; i < 40; i++) begin
      sel_btn = ((i / 2) % 2) == 1;
      cyc();
    end
    sel_btn = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    chk("bounce_src", 64'(out_src2), 64'd0);

    // Auto-cycling on the 3-source unit from a clean reset
    async_reset();
    auto_en = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      prev = out_src3;
      cyc();
      if (out_src3 != prev) begin
        q_cyc.push_back(i);
        q_val.push_back(out_src3);
      end
    end
    chk("auto_nchg", 64'(q_cyc.size()), 64'd3);
    for (int i = 0; i < q_cyc.size(); i++) begin
      chk("auto_val", 64'(q_val[i]), 64'((i + 1) % 3));
      chk("auto_when", 64'(q_cyc[i]), 64'(11 + 10 * i));
    end

    // Press debounced on the same edge as an auto-advance
    for (int i = 0; i < 20 && m_dw[1] != 4; i++) cyc();
    prev = out_src3;
    nchg = 0;
    sel_btn = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      sv = out_src3;
      cyc();
      if (i == DEB + 2) sel_btn = 1'b0;
      if (out_src3 != sv) nchg++;
    end
    chk("simul_nchg", 64'(nchg), 64'd1);
    chk("simul_val", 64'(out_src3), 64'((prev + 1) % 3));
    auto_en = 1'b0;
    for (int i = 0; i < 10; i++) cyc();

    // Hold
    src_data = {16'h7777, 16'hABCD, 16'h1234};
    src_valid = 3'b111;
    cyc();
    src_valid = 3'b000;
    cyc(); cyc();
    sd = out_dig2;
    sv = out_src2;
    hold = 1'b1;
    src_data[15:0] = 16'h5555;
    src_valid = 3'b001;
    cyc();
    src_valid = 3'b000;
    sel_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == DEB + 2) sel_btn = 1'b0;
      cyc();
      chk("hold_upd", 64'(out_upd2), 64'd0);
      chk("hold_dig", 64'(out_dig2), 64'(sd));
      chk("hold_src", 64'(out_src2), 64'(sv));
    end
    hold = 1'b0;
    cyc();
    chk("unhold_src", 64'(out_src2), 64'((sv + 1) % 2));
    chk("unhold_dig", 64'(out_dig2), (sv == 0) ? 64'hABCD : 64'h5555);
    chk("unhold_upd", 64'(out_upd2), 64'd1);
    cyc();
    chk("unhold_upd_once", 64'(out_upd2), 64'd0);

    // Reset mid-dwell with idx=2 on the 3-source unit
    auto_en = 1'b1;
    for (int i = 0; i < 80 && !(m_idx[1] == 2 && m_dw[1] == 7); i++) cyc();
    async_reset();
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (out_src3 != 0) begin
        n = i;
        break;
      end
    end
    chk("rst_restart", 64'(n), 64'd11);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      src_valid = 3'($urandom_range(0, 7));
      src_data  = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0)  sel_btn = ~sel_btn;
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      if ($urandom_range(0, 31) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 299) == 0) async_reset();
      else cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/display_source_mux.md
DISPLAY_SOURCE_MUX -- requirements
Module: display_source_mux

Interface
REQ-001 The block SHALL have parameter DIG_W, default 4: bits per display digit.
REQ-002 The block SHALL have parameter CHANNELS, default 4: digits per source.
REQ-003 The block SHALL have parameter SOURCES, default 2 (legal range 2..16): number of selectable digit sets.
REQ-004 The block SHALL have parameter DWELL, default 50_000_000: clock cycles per auto-cycle step (>=2).
REQ-005 The block SHALL have parameter DEB, default 16: stable cycles the debounce requires (>=2).
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have the remaining ports:
- src_data  in  SOURCES*CHANNELS*DIG_W  source s, channel c at bits [(s*CHANNELS+c)*DIG_W +: DIG_W].
- src_valid  in  SOURCES  bit s high = capture source s this cycle.
- sel_btn  in  1  raw, asynchronous manual-advance button.
- auto_en  in  1  enable auto-cycling.
- hold  in  1  freeze displayed outputs.
- out_dig  out  CHANNELS*DIG_W  displayed digits, channel c at [c*DIG_W +: DIG_W].
- out_src  out  SW=max(1,clog2(SOURCES))  index of displayed source.
- out_upd  out  1  one-cycle pulse when out_dig or out_src changes.

Function
REQ-008 The block SHALL hold one snapshot register per source; snap[s] loads source s's slice of src_data on any cycle src_valid[s]=1, and retains its value otherwise.
REQ-009 Snapshots SHALL capture independently: multiple src_valid bits in one cycle load all flagged sources.
REQ-010 sel_btn SHALL pass through a 2-flop synchronizer before any use.
REQ-011 The debounced level SHALL change only after the synchronized input differs from it for DEB consecutive cycles; any intermediate match SHALL reset the count to 0.
REQ-012 A 0->1 transition of the debounced level SHALL produce one manual-advance event.
REQ-013 While auto_en=1, a dwell counter SHALL increment every cycle; on reaching DWELL-1 it SHALL produce one auto-advance event and wrap to 0.
REQ-014 While auto_en=0, the dwell counter SHALL be held at 0.
REQ-015 A manual-advance event SHALL clear the dwell counter to 0.
REQ-016 An advance event SHALL set idx <= (idx==SOURCES-1) ? 0 : idx+1.
REQ-017 Simultaneous manual- and auto-advance events SHALL advance idx exactly once, and the dwell counter SHALL clear.
REQ-018 When hold=0, each cycle the block SHALL register out_dig <= snap[idx] and out_src <= idx, using the current-cycle values of snap and idx.
REQ-019 Latency from src_valid (or an advance event) to out_dig/out_src SHALL be 2 cycles.
REQ-020 When hold=1, out_dig and out_src SHALL keep their values; snapshots, idx and counters SHALL continue to operate.
REQ-021 On hold deassertion, the outputs SHALL show snap[idx] on the next registered update.
REQ-022 out_upd SHALL be registered and high for exactly the cycle in which out_dig or out_src first shows a new value; it SHALL be 0 while hold=1.
REQ-023 With SOURCES=2 and auto_en=0, the block SHALL behave as a registered two-way digit selector toggled by the button.

Reset
REQ-024 Assertion of reset_n=0 SHALL immediately clear all snapshots, idx, the dwell and debounce counters, the synchronizer flops, the debounced level, out_dig, out_src and out_upd to 0, including mid-operation.
REQ-025 After reset_n deassertion, the first captures SHALL occur on the first rising edge with src_valid set, and an already-pressed button SHALL register as one advance once debounced.

Verification
REQ-026 The bench SHALL cover capture: reset; src_valid=2'b11, source0=16'h1234, source1=16'hABCD -> 2 cycles later out_dig=16'h1234, out_src=0, out_upd pulses once.
REQ-027 The bench SHALL cover manual advance: clean press of DEB+2 cycles with DEB=4 -> out_src=1, out_dig=16'hABCD; a second press -> out_src=0 (wrap).
REQ-028 The bench SHALL cover bounce: sel_btn toggling every 2 cycles for 40 cycles with DEB=4, then released -> no advance, out_src unchanged.
REQ-029 The bench SHALL cover auto-cycling: SOURCES=3, DWELL=10, auto_en=1 -> out_src sequence 0,1,2,0, changing every 10 cycles; a press debounced on the same cycle as auto-advance -> a single step.
REQ-030 The bench SHALL cover hold: hold=1, new source0 data 16'h5555, then one advance -> outputs unchanged and out_upd=0; hold=0 -> next cycle outputs snap[idx] with one out_upd pulse.
REQ-031 The bench SHALL cover reset mid-dwell: reset_n pulsed low at dwell count 7 with idx=2 -> all outputs 0 asynchronously, and the dwell counter restarts from 0.
